// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: two-requester round-robin arbiter feeding one Ethernet TX
// byte stream. The byte path from the granted requester is combinational,
// so there is no added latency. Grant, round-robin pointer, stall watchdog
// and inter-frame gap are registered.
// Optional feature macro: ETH_ARB_IFG_EN. When defined, a GAP state inserts
// IFG_CYCLES idle cycles after every frame or abort. When undefined, frames
// and aborts return straight to IDLE and IFG_CYCLES has no effect.
module eth_tx_arbiter #(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_req0_data,
    input  logic       i_req0_valid,
    input  logic       i_req0_last,
    output logic       o_req0_ready,
    input  logic [7:0] i_req1_data,
    input  logic       i_req1_valid,
    input  logic       i_req1_last,
    output logic       o_req1_ready,
    output logic [7:0] o_wdata,
    output logic       o_wvalid,
    output logic       o_wlast,
    input  logic       i_wready,
    output logic [1:0] o_grant,
    output logic       o_busy,
    output logic       o_timeout
);

    localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

`ifdef ETH_ARB_IFG_EN
    localparam int unsigned GAP_W = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    logic [GAP_W-1:0] gap_cnt_q;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // IFG_CYCLES has no effect when the gap feature is compiled out.
    logic unused_ifg;
    assign unused_ifg = ^IFG_CYCLES;
`endif

    state_e          state_q;
    state_e          done_state;
    logic [1:0]      grant_q;
    logic            ptr_q;       // 1: requester 1 wins a tie, 0: requester 0 wins
    logic [WD_W-1:0] wd_cnt_q;
    logic [WD_W-1:0] wd_cnt_d;
    logic            timeout_q;

    logic [7:0]      sel_data;
    logic            sel_valid;
    logic            sel_last;
    logic            in_send;
    logic            xfer;
    logic            stall;
    logic            wd_expire;
    logic [1:0]      arb_grant;

    // Select the granted requester's byte, valid and last.
    always_comb begin
        // NOTE: give every always_comb output a default first; a path that leaves one unassigned infers a latch.
        sel_data  = 8'h00;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        if (grant_q[0]) begin
            sel_data  = i_req0_data;
            sel_valid = i_req0_valid;
            sel_last  = i_req0_last;
        end else if (grant_q[1]) begin
            sel_data  = i_req1_data;
            sel_valid = i_req1_valid;
            sel_last  = i_req1_last;
        end
    end

    assign in_send      = (state_q == ST_SEND);
    assign o_wdata      = in_send ? sel_data : 8'h00;
    assign o_wvalid     = in_send && sel_valid;
    assign o_wlast      = in_send && sel_last;
    assign o_req0_ready = in_send && grant_q[0] && i_wready;
    assign o_req1_ready = in_send && grant_q[1] && i_wready;
    assign xfer         = o_wvalid && i_wready;

    // Only cycles where the owner has nothing to offer count as a stall;
    // downstream back-pressure neither counts nor clears the watchdog.
    assign stall     = in_send && !sel_valid;
    assign wd_expire = stall && (wd_cnt_q == WD_W'(TIMEOUT - 1));

    // Next watchdog count: clear on a transfer, step on a stall, else hold.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (xfer) begin
            wd_cnt_d = '0;
        end else if (stall) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    // Arbitration decision used in IDLE: sole requester wins, tie goes to the pointer.
    always_comb begin
        arb_grant = 2'b00;
        if (i_req0_valid && i_req1_valid) begin
            arb_grant = ptr_q ? 2'b10 : 2'b01;
        end else if (i_req0_valid) begin
            arb_grant = 2'b01;
        end else if (i_req1_valid) begin
            arb_grant = 2'b10;
        end
    end

    // Where a finished or aborted frame goes next.
    always_comb begin
`ifdef ETH_ARB_IFG_EN
        done_state = ST_GAP;
        if (IFG_CYCLES == 0) begin
            done_state = ST_IDLE;
        end
`else
        done_state = ST_IDLE;
`endif
    end

    // Arbiter FSM: grant ownership, pointer, watchdog, gap and abort pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'b00;
            ptr_q     <= 1'b0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`ifdef ETH_ARB_IFG_EN
            gap_cnt_q <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_grant != 2'b00) begin
                        grant_q  <= arb_grant;
                        wd_cnt_q <= '0;
                        state_q  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if ((xfer && sel_last) || wd_expire) begin
                        // Frame over (normally or aborted): hand priority to the other side.
                        grant_q   <= 2'b00;
                        ptr_q     <= grant_q[0];
                        wd_cnt_q  <= '0;
                        timeout_q <= wd_expire;
                        state_q   <= done_state;
                    end else begin
                        wd_cnt_q <= wd_cnt_d;
                    end
                end
`ifdef ETH_ARB_IFG_EN
                ST_GAP: begin
                    if (gap_cnt_q == GAP_W'(IFG_CYCLES - 1)) begin
                        gap_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_grant   = grant_q;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_timeout = timeout_q;

endmodule
